// File: rtl/alu_seq_if.sv
// alu_seq_if: request/response bundle for the sequential ALU.
//   master (execute stage): drives in_valid/a/b/op and out_ready.
//   slave  (alu_seq):       drives in_ready, out_valid, result, result_hi and the flags.
interface alu_seq_if #(
    parameter int unsigned WIDTH = 16
) ();
    // Request side
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [3:0]       op;

    // Response side
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] result;
    logic [WIDTH-1:0] result_hi;
    logic             zero;
    logic             carry;
    logic             ovf;
    logic             dbz;

    modport master (
        output in_valid, a, b, op, out_ready,
        input  in_ready, out_valid, result, result_hi, zero, carry, ovf, dbz
    );

    modport slave (
        input  in_valid, a, b, op, out_ready,
        output in_ready, out_valid, result, result_hi, zero, carry, ovf, dbz
    );
endinterface

// File: rtl/alu_seq.sv
// alu_seq: registered ALU with valid/ready handshake on both sides.
// Single-cycle ops (ADD/SUB/NOT/SLL/SRL/AND/OR/SLT/SLTS/SRA) are computed at the accept
// edge and presented the next cycle. MUL (shift-add) and DIVU (restoring) iterate for
// WIDTH cycles in CALC. DIVU by zero completes immediately with dbz set.
// Ports:
//   clk  - clock, rising edge
//   rst  - asynchronous active-high reset
//   bus  - alu_seq_if.slave: in_valid/in_ready/a/b/op request, out_valid/out_ready,
//          result/result_hi and zero/carry/ovf/dbz response
module alu_seq #(
    parameter int unsigned WIDTH = 16
) (
    input logic      clk,
    input logic      rst,
    alu_seq_if.slave bus
);
    localparam int unsigned CNT_W = $clog2(WIDTH) + 1;
    localparam int unsigned SH_W  = $clog2(WIDTH);

    localparam logic [WIDTH-1:0] ShiftMax = WIDTH'(WIDTH - 1);
    localparam logic [CNT_W-1:0] LastIter = CNT_W'(WIDTH - 1);

    localparam logic [3:0] OpAdd  = 4'd0;
    localparam logic [3:0] OpSub  = 4'd1;
    localparam logic [3:0] OpNot  = 4'd2;
    localparam logic [3:0] OpSll  = 4'd3;
    localparam logic [3:0] OpSrl  = 4'd4;
    localparam logic [3:0] OpAnd  = 4'd5;
    localparam logic [3:0] OpOr   = 4'd6;
    localparam logic [3:0] OpSlt  = 4'd7;
    localparam logic [3:0] OpMul  = 4'd8;
    localparam logic [3:0] OpDivu = 4'd9;
    localparam logic [3:0] OpSlts = 4'd10;
    localparam logic [3:0] OpSra  = 4'd11;

    typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

    state_e           state_q;
    logic [CNT_W-1:0] cnt_q;
    logic             mul_q;       // 1: CALC runs MUL, 0: CALC runs DIVU
    logic [WIDTH-1:0] opb_q;       // captured multiplicand / divisor
    logic [WIDTH-1:0] hi_q;        // MUL partial high word / DIVU partial remainder
    logic [WIDTH-1:0] lo_q;        // MUL multiplier->low word / DIVU dividend->quotient
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_hi_q;
    logic             zero_q;
    logic             carry_q;
    logic             ovf_q;
    logic             dbz_q;
    logic             out_valid_q;

    // Single-cycle datapath, evaluated on the live request inputs.
    logic [WIDTH:0]          sum_ext;
    logic [WIDTH:0]          dif_ext;
    logic [SH_W-1:0]         shamt;
    logic                    big_shift;
    logic signed [WIDTH-1:0] sra_res;
    logic                    slts;
    logic [WIDTH-1:0]        alu_res;
    logic                    alu_carry;
    logic                    alu_ovf;

    always_comb begin
        sum_ext   = {1'b0, bus.a} + {1'b0, bus.b};
        dif_ext   = {1'b0, bus.a} - {1'b0, bus.b};
        shamt     = bus.b[SH_W-1:0];
        big_shift = bus.b > ShiftMax;
        sra_res   = $signed(bus.a) >>> shamt;
        slts      = $signed(bus.a) < $signed(bus.b);
        alu_res   = sum_ext[WIDTH-1:0];
        alu_carry = 1'b0;
        alu_ovf   = 1'b0;
        case (bus.op)
            OpSub: begin
                alu_res   = dif_ext[WIDTH-1:0];
                alu_carry = dif_ext[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] != bus.b[WIDTH-1]) &&
                            (dif_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
            OpNot:  alu_res = ~bus.a;
            OpSll:  alu_res = big_shift ? '0 : bus.a << shamt;
            OpSrl:  alu_res = big_shift ? '0 : bus.a >> shamt;
            OpAnd:  alu_res = bus.a & bus.b;
            OpOr:   alu_res = bus.a | bus.b;
            OpSlt:  alu_res = {{(WIDTH-1){1'b0}}, bus.a < bus.b};
            OpSlts: alu_res = {{(WIDTH-1){1'b0}}, slts};
            OpSra:  alu_res = big_shift ? {WIDTH{bus.a[WIDTH-1]}} : sra_res;
            default: begin
                // ADD, plus 12-15 which alias ADD
                alu_res   = sum_ext[WIDTH-1:0];
                alu_carry = sum_ext[WIDTH];
                alu_ovf   = (bus.a[WIDTH-1] == bus.b[WIDTH-1]) &&
                            (sum_ext[WIDTH-1] != bus.a[WIDTH-1]);
            end
        endcase
    end

    // One MUL or DIVU iteration step from the current partial state.
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_sh;
    logic [WIDTH:0]   div_dif;
    logic             div_ge;
    logic [WIDTH-1:0] iter_hi;
    logic [WIDTH-1:0] iter_lo;

    always_comb begin
        mul_sum = {1'b0, hi_q} + (lo_q[0] ? {1'b0, opb_q} : '0);
        div_sh  = {hi_q, lo_q[WIDTH-1]};
        div_dif = div_sh - {1'b0, opb_q};
        // Partial remainder < divisor keeps div_sh < 2*divisor, so bit WIDTH of the
        // difference is set exactly when the trial subtraction goes negative.
        div_ge  = ~div_dif[WIDTH];
        if (mul_q) begin
            iter_hi = mul_sum[WIDTH:1];
            iter_lo = {mul_sum[0], lo_q[WIDTH-1:1]};
        end else begin
            iter_hi = div_ge ? div_dif[WIDTH-1:0] : div_sh[WIDTH-1:0];
            iter_lo = {lo_q[WIDTH-2:0], div_ge};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            mul_q       <= 1'b0;
            opb_q       <= '0;
            hi_q        <= '0;
            lo_q        <= '0;
            result_q    <= '0;
            result_hi_q <= '0;
            zero_q      <= 1'b0;
            carry_q     <= 1'b0;
            ovf_q       <= 1'b0;
            dbz_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.in_valid) begin
                        opb_q <= bus.b;
                        cnt_q <= '0;
                        hi_q  <= '0;
                        lo_q  <= bus.a;
                        if (bus.op == OpMul || (bus.op == OpDivu && bus.b != '0)) begin
                            mul_q   <= (bus.op == OpMul);
                            state_q <= StCalc;
                        end else begin
                            state_q     <= StDone;
                            out_valid_q <= 1'b1;
                            if (bus.op == OpDivu) begin
                                result_q    <= '1;
                                result_hi_q <= bus.a;
                                zero_q      <= 1'b0;
                                carry_q     <= 1'b0;
                                ovf_q       <= 1'b0;
                                dbz_q       <= 1'b1;
                            end else begin
                                result_q    <= alu_res;
                                result_hi_q <= '0;
                                zero_q      <= (alu_res == '0);
                                carry_q     <= alu_carry;
                                ovf_q       <= alu_ovf;
                                dbz_q       <= 1'b0;
                            end
                        end
                    end
                end
                StCalc: begin
                    hi_q  <= iter_hi;
                    lo_q  <= iter_lo;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == LastIter) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b1;
                        result_q    <= iter_lo;
                        result_hi_q <= iter_hi;
                        zero_q      <= (iter_lo == '0);
                        carry_q     <= 1'b0;
                        ovf_q       <= 1'b0;
                        dbz_q       <= 1'b0;
                    end
                end
                StDone: begin
                    if (bus.out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= StIdle;
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == StIdle);
    assign bus.out_valid = out_valid_q;
    assign bus.result    = result_q;
    assign bus.result_hi = result_hi_q;
    assign bus.zero      = zero_q;
    assign bus.carry     = carry_q;
    assign bus.ovf       = ovf_q;
    assign bus.dbz       = dbz_q;
endmodule

// File: tb/tb_alu_seq.sv
// tb_alu_seq: directed-vector bench for alu_seq with a queue scoreboard. The stimulus
// process pushes hand-computed expectations; a negedge monitor pops and compares them
// at every result handoff.
module tb_alu_seq;
    localparam int unsigned W = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    alu_seq_if #(.WIDTH(W)) bus ();

    alu_seq #(.WIDTH(W)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          id;
        logic [15:0] res;
        logic [15:0] hi;
        logic        z;
        logic        c;
        logic        o;
        logic        d;
    } exp_t;

    exp_t sb_q[$];
    int   checks   = 0;
    int   failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: a handoff happens at the next posedge when out_valid && out_ready here.
    always @(negedge clk) begin : mon
        exp_t e;
        if (!rst && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            if (sb_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_output: got result 0x%0h expected no output",
                         bus.result);
            end else begin
                e = sb_q.pop_front();
                chk($sformatf("op%0d_result", e.id), 32'(bus.result), 32'(e.res));
                chk($sformatf("op%0d_result_hi", e.id), 32'(bus.result_hi), 32'(e.hi));
                chk($sformatf("op%0d_flags_zcod", e.id),
                    32'({bus.zero, bus.carry, bus.ovf, bus.dbz}),
                    32'({e.z, e.c, e.o, e.d}));
            end
        end
    end

    // Issue one op (called #1 after a posedge with the DUT idle), check latency,
    // busy in_ready and the handoff. out_ready is expected to be 1.
    task automatic issue(input int id, input logic [3:0] op, input logic [15:0] a,
                         input logic [15:0] b, input logic [15:0] res, input logic [15:0] hi,
                         input logic z, input logic c, input logic o, input logic d,
                         input int lat);
        exp_t e;
        int   cyc;
        logic busy_ok;
        e.id = id; e.res = res; e.hi = hi; e.z = z; e.c = c; e.o = o; e.d = d;
        sb_q.push_back(e);
        chk($sformatf("op%0d_in_ready_idle", id), 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.a        = a;
        bus.b        = b;
        bus.op       = op;
        @(posedge clk);
        #1;
        // Scramble inputs after accept; the DUT must use captured operands.
        bus.in_valid = 1'b0;
        bus.a        = 16'hDEAD;
        bus.b        = 16'hBEEF;
        bus.op       = 4'hF;
        cyc     = 1;
        busy_ok = 1'b1;
        while (bus.out_valid !== 1'b1 && cyc < 64) begin
            if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
            @(posedge clk);
            #1;
            cyc++;
        end
        if (bus.in_ready !== 1'b0) busy_ok = 1'b0;
        chk($sformatf("op%0d_latency", id), 32'(cyc), 32'(lat));
        chk($sformatf("op%0d_busy_in_ready_low", id), 32'(busy_ok), 32'd1);
        @(posedge clk);
        #1;
        chk($sformatf("op%0d_out_valid_drop", id), 32'(bus.out_valid), 32'd0);
        chk($sformatf("op%0d_in_ready_back", id), 32'(bus.in_ready), 32'd1);
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        exp_t e;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.op        = '0;
        bus.out_ready = 1'b1;
        #1 rst = 1'b1;
        #2;
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        chk("reset_result", 32'({bus.result, bus.result_hi}), 32'd0);
        chk("reset_flags", 32'({bus.zero, bus.carry, bus.ovf, bus.dbz}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;

        //    id op     a         b         result    result_hi z     c     o     d     lat
        issue(1,  4'd0,  16'h7FFF, 16'h0001, 16'h8000, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        issue(2,  4'd1,  16'h0005, 16'h0005, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        issue(3,  4'd8,  16'hFFFF, 16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0, 1'b0, 17);
        issue(4,  4'd9,  16'd100,  16'd7,    16'h000E, 16'h0002, 1'b0, 1'b0, 1'b0, 1'b0, 17);
        issue(5,  4'd7,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        issue(6,  4'd10, 16'hFFFF, 16'h0001, 16'h0001, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue(7,  4'd11, 16'h8000, 16'h0004, 16'hF800, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue(8,  4'd4,  16'h8000, 16'h0004, 16'h0800, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue(9,  4'd3,  16'h0001, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        issue(10, 4'd11, 16'h8000, 16'h0014, 16'hFFFF, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue(11, 4'd4,  16'hFFFF, 16'h0010, 16'h0000, 16'h0000, 1'b1, 1'b0, 1'b0, 1'b0, 1);
        issue(12, 4'd0,  16'hFFFF, 16'h0001, 16'h0000, 16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1);
        issue(13, 4'd1,  16'h0001, 16'h0002, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1);
        issue(14, 4'd1,  16'h8000, 16'h0001, 16'h7FFF, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1);
        issue(15, 4'd2,  16'h00FF, 16'h0000, 16'hFF00, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue(16, 4'd5,  16'hF0F0, 16'h3C3C, 16'h3030, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue(17, 4'd3,  16'h0003, 16'h0004, 16'h0030, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue(18, 4'd13, 16'h0002, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);
        issue(19, 4'd8,  16'h0003, 16'h0005, 16'h000F, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 17);
        issue(20, 4'd9,  16'hFFFF, 16'h0010, 16'h0FFF, 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 17);
        issue(21, 4'd9,  16'h0005, 16'h0009, 16'h0000, 16'h0005, 1'b1, 1'b0, 1'b0, 1'b0, 17);

        // Backpressure on an OR result while the request inputs churn.
        bus.out_ready = 1'b0;
        e.id = 30; e.res = 16'h1234; e.hi = 16'h0000; e.z = 0; e.c = 0; e.o = 0; e.d = 0;
        sb_q.push_back(e);
        bus.in_valid = 1'b1;
        bus.a        = 16'h1200;
        bus.b        = 16'h0034;
        bus.op       = 4'd6;
        @(posedge clk);
        #1;
        chk("bp_latency_valid", 32'(bus.out_valid), 32'd1);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = 1'b1;
            bus.a        = 16'(16'h0101 * (i + 1));
            bus.b        = 16'(16'h0011 * (i + 3));
            bus.op       = 4'(i * 2);
            @(posedge clk);
            #1;
            chk($sformatf("bp_hold_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_hold_in_ready_%0d", i), 32'(bus.in_ready), 32'd0);
            chk($sformatf("bp_hold_result_%0d", i), 32'({bus.result, bus.result_hi}),
                32'h1234_0000);
            chk($sformatf("bp_hold_flags_%0d", i),
                32'({bus.zero, bus.carry, bus.ovf, bus.dbz}), 32'd0);
        end
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("bp_release_valid", 32'(bus.out_valid), 32'd0);
        chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
        chk("bp_result_kept", 32'(bus.result), 32'h1234);

        issue(22, 4'd9,  16'h1234, 16'h0000, 16'hFFFF, 16'h1234, 1'b0, 1'b0, 1'b0, 1'b1, 1);

        // Reset during cycle 8 of a MUL; its result must never appear.
        bus.in_valid = 1'b1;
        bus.a        = 16'hFFFF;
        bus.b        = 16'hFFFF;
        bus.op       = 4'd8;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        repeat (7) begin
            @(posedge clk);
            #1;
        end
        chk("midop_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("midop_rst_result", 32'({bus.result, bus.result_hi}), 32'd0);
        chk("midop_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("midop_rst_flags", 32'({bus.zero, bus.carry, bus.ovf, bus.dbz}), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        chk("midop_in_ready_after", 32'(bus.in_ready), 32'd1);
        issue(23, 4'd0,  16'h0002, 16'h0003, 16'h0005, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0, 1);

        repeat (3) @(posedge clk);
        chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/alu_seq.md
Name: alu_seq

Overview:
- Parametrised, registered successor to the processor's 16-bit combinational ALU.
- Keeps opcodes 0-7 with the same semantics: ADD, SUB, NOT, SLL, SRL, AND, OR, SLT.
- Adds signed compare, arithmetic shift right, and iterative multi-cycle MUL and DIVU.
- Adds flags and a valid/ready handshake on both sides, so the execute stage can stall on long ops.

Parameters:
- WIDTH, 16, operand and result width in bits (>=4, power of two).
- CNT_W, $clog2(WIDTH)+1, iteration counter width (derived, not overridden).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- in_valid  in  1  operands and op are valid.
- in_ready  out  1  block can accept an op (high only in IDLE).
- a  in  WIDTH  operand A.
- b  in  WIDTH  operand B.
- op  in  4  operation select.
- out_valid  out  1  result and flags are valid.
- out_ready  in  1  consumer accepts the result.
- result  out  WIDTH  primary result; quotient for DIVU; low word for MUL.
- result_hi  out  WIDTH  MUL high word; DIVU remainder; 0 for all other ops.
- zero  out  1  result == 0 (low word only).
- carry  out  1  ADD: carry-out. SUB: borrow (a<b unsigned). Otherwise 0.
- ovf  out  1  signed overflow for ADD/SUB. Otherwise 0.
- dbz  out  1  DIVU with b == 0.

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - State goes to IDLE.
  - result, result_hi, zero, carry, ovf, dbz, out_valid all go to 0.
  - in_ready is 1 after reset.
  - An in-flight op is discarded.
- Accept: an op is accepted on a rising edge with in_valid && in_ready. a, b and op are captured at that edge; later input changes have no effect.
- FSM states: IDLE, CALC, DONE.
  - IDLE -> DONE on accept of a single-cycle op, or of DIVU with b == 0.
  - IDLE -> CALC on accept of MUL or DIVU with b != 0.
  - CALC -> DONE after exactly WIDTH iteration edges, tracked by a counter.
  - DONE -> IDLE on out_valid && out_ready.
  - A new op cannot be accepted in the same cycle as result handoff; in_ready rises the cycle after handoff.
- Latency, counting the accept cycle as cycle 0:
  - Single-cycle ops and DIVU with b == 0: out_valid is high in cycle 1.
  - MUL and DIVU with b != 0: out_valid is high in cycle WIDTH+1.
- Output hold: while out_valid is high and out_ready is low, all outputs hold stable. out_valid stays high until handoff, then drops to 0. The result registers keep their last value.
- Opcodes:
  - 0 ADD: a+b, mod 2^WIDTH.
  - 1 SUB: a-b.
  - 2 NOT: ~a.
  - 3 SLL: a<<b.
  - 4 SRL: a>>b, logical.
  - 5 AND: a&b.
  - 6 OR: a|b.
  - 7 SLT: 1 if a<b unsigned, else 0.
  - 8 MUL: unsigned shift-add. {result_hi,result} = full 2*WIDTH-bit product.
  - 9 DIVU: restoring division, one quotient bit per CALC cycle. result = quotient, result_hi = remainder.
  - 10 SLTS: 1 if a<b signed, else 0.
  - 11 SRA: arithmetic shift right by b.
  - 12-15: behave exactly as ADD.
- Shift rules (SLL, SRL, SRA) when b >= WIDTH:
  - SLL and SRL give 0.
  - SRA gives all copies of a[WIDTH-1].
- DIVU with b == 0: result = all ones, result_hi = a, dbz = 1. Completes via IDLE -> DONE directly.
- Flags are registered with result and valid only while out_valid is high. dbz is 0 for every op other than DIVU.
- in_valid while busy (CALC or DONE) is ignored; no queuing.

Test Plan:
- ADD a=0x7FFF, b=0x0001 -> result 0x8000, ovf=1, carry=0, zero=0, out_valid in cycle 1. Then SUB a=0x0005, b=0x0005 -> result 0x0000, zero=1, carry=0, ovf=0.
- MUL a=0xFFFF, b=0xFFFF -> result 0x0001, result_hi 0xFFFE. out_valid first high exactly in cycle 17; in_ready low in cycles 1-17.
- DIVU a=100, b=7 -> result 0x000E, result_hi 0x0002, dbz=0, cycle 17. DIVU a=0x1234, b=0 -> result 0xFFFF, result_hi 0x1234, dbz=1, cycle 1.
- Compare and shifts with a=0xFFFF, b=0x0001: SLT -> 0, SLTS -> 1. SRA a=0x8000, b=4 -> 0xF800. SRL a=0x8000, b=4 -> 0x0800. SLL a=0x0001, b=16 -> 0x0000.
- Backpressure: hold out_ready=0 for 5 cycles after an OR result; change a, b, op and in_valid meanwhile.
  - Required: outputs stable, in_ready stays 0, and the input changes are ignored.
  - Then assert out_ready: out_valid drops next cycle and in_ready rises.
- Reset mid-op: assert rst in cycle 8 of a MUL.
  - Required: all outputs 0 immediately (asynchronous), in_ready=1 after release.
  - A following ADD 2+3 -> 0x0005 in cycle 1.
